// File: rtl/byte_lane_insert.sv
// byte_lane_insert: LLB/LHB byte-lane insert unit with one-deep write stage and self-forwarding
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_op/in_rd/in_imm instruction in;
//   rf_rd_reg/rf_rd_data register-file read; wr_en/wr_reg/wr_data/wr_ready write port handshake.
// Optional: BYTE_INSERT_STALL_CNT_EN adds stall_clr input and 16-bit saturating stall_cnt output.
module byte_lane_insert #(
  parameter int NREG = 16,
  parameter int ZERO_REG = 1,
  localparam int RW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_op,
  input  logic [RW-1:0] in_rd,
  input  logic [7:0]    in_imm,
  output logic [RW-1:0] rf_rd_reg,
  input  logic [15:0]   rf_rd_data,
  output logic          wr_en,
  output logic [RW-1:0] wr_reg,
  output logic [15:0]   wr_data,
`ifdef BYTE_INSERT_STALL_CNT_EN
  input  logic          stall_clr,
  output logic [15:0]   stall_cnt,
`endif
  input  logic          wr_ready
);
  logic          wr_en_q, wr_en_d;
  logic [RW-1:0] wr_reg_q, wr_reg_d;
  logic [15:0]   wr_data_q, wr_data_d;
  logic [15:0]   old_val, merged;
  logic          accept, load;
  assign in_ready  = !wr_en_q || wr_ready;
  assign rf_rd_reg = in_rd;
  assign accept    = in_valid && in_ready;
  // R0 instructions are consumed but never reach the write stage
  assign load      = accept && !((ZERO_REG != 0) && (in_rd == '0));
  // the pending write lands in the register file at this edge, so it is newer than rf_rd_data
  assign old_val   = (wr_en_q && wr_reg_q == in_rd) ? wr_data_q : rf_rd_data;
  assign merged    = in_op ? {in_imm, old_val[7:0]} : {old_val[15:8], in_imm};
  always_comb begin
    wr_en_d   = load ? 1'b1 : (wr_ready ? 1'b0 : wr_en_q);
    wr_reg_d  = load ? in_rd : wr_reg_q;
    wr_data_d = load ? merged : wr_data_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end
  assign wr_en   = wr_en_q;
  assign wr_reg  = wr_reg_q;
  assign wr_data = wr_data_q;
`ifdef BYTE_INSERT_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n || stall_clr) stall_cnt_q <= '0;
    else if (wr_en_q && !wr_ready && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
  end
  assign stall_cnt = stall_cnt_q;
`endif
endmodule
